// File: rtl/delay_pkg.sv
// Shared types and constants for the key debounce back-end.
package delay_pkg;

    localparam int unsigned FILT_W = 19;
    localparam int unsigned HOLD_W = 26;

    localparam logic [FILT_W-1:0] T10MS_DEF = 19'd499_999;
    localparam logic [HOLD_W-1:0] TLONG_DEF = 26'd49_999_999;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } state_e;

    // Key counts as held once a press is confirmed and until a release is confirmed.
    function automatic logic is_held(input state_e s);
        return (s == HELD) || (s == REL_FILT);
    endfunction

endpackage

// File: rtl/timer_module.sv
// Saturating up-counter with clear priority; done flags counter == term.
module timer_module #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != term)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == term);

endmodule

// File: rtl/delay_module_2.sv
// Key debounce back-end: confirms press/release edges after a quiet window.
// Optional long-press detector enabled by defining DELAY_LONG_PRESS_EN.
module delay_module_2
    import delay_pkg::*;
#(
    parameter logic [FILT_W-1:0] T10MS = T10MS_DEF,
    parameter logic [HOLD_W-1:0] TLONG = TLONG_DEF
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Pin_Out,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Long_Pulse
);

    state_e state_q, state_d;
    logic   pin_out_q, pin_out_d;
    logic   press_q, press_d;
    logic   release_q, release_d;
    logic   h2l_c, l2h_c;
    logic   filt_clr_c, filt_en_c, filt_done_c;

    // Coincident edges cancel each other out.
    assign h2l_c = H2L_Sig & ~L2H_Sig;
    assign l2h_c = L2H_Sig & ~H2L_Sig;

    always_comb begin
        state_d    = state_q;
        filt_clr_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (h2l_c) begin
                    state_d    = PRESS_FILT;
                    filt_clr_c = 1'b1;
                end
            end
            PRESS_FILT: begin
                if (l2h_c) begin
                    state_d = IDLE;
                end else if (h2l_c) begin
                    filt_clr_c = 1'b1;
                end else if (filt_done_c) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (l2h_c) begin
                    state_d    = REL_FILT;
                    filt_clr_c = 1'b1;
                end
            end
            REL_FILT: begin
                if (h2l_c) begin
                    state_d = HELD;
                end else if (l2h_c) begin
                    filt_clr_c = 1'b1;
                end else if (filt_done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Filter counter rests at zero whenever no window is open.
        if ((state_d == IDLE) || (state_d == HELD)) begin
            filt_clr_c = 1'b1;
        end
        pin_out_d = is_held(state_d);
        press_d   = (state_q == PRESS_FILT) && (state_d == HELD);
        release_d = (state_q == REL_FILT) && (state_d == IDLE);
    end

    assign filt_en_c = (state_q == PRESS_FILT) || (state_q == REL_FILT);

    timer_module #(.W(FILT_W)) u_filt_timer (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (filt_clr_c),
        .en    (filt_en_c),
        .term  (T10MS),
        .done  (filt_done_c)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            pin_out_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pin_out_q <= pin_out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign Pin_Out       = pin_out_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;

`ifdef DELAY_LONG_PRESS_EN
    logic hold_clr_c, hold_en_c, hold_done_c;
    logic hold_done_q;
    logic long_q, long_d;

    // Hold timer restarts only on a fresh confirmed press, not on a release bounce.
    assign hold_clr_c = (state_q == PRESS_FILT) && (state_d == HELD);
    assign hold_en_c  = is_held(state_q);
    assign long_d     = hold_done_c & ~hold_done_q;

    timer_module #(.W(HOLD_W)) u_hold_timer (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (hold_clr_c),
        .en    (hold_en_c),
        .term  (TLONG),
        .done  (hold_done_c)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hold_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_done_q <= hold_done_c;
            long_q      <= long_d;
        end
    end

    assign Long_Pulse = long_q;
`else
    logic unused_tlong;
    assign unused_tlong = ^TLONG;
    assign Long_Pulse   = 1'b0;
`endif

endmodule

// File: tb/tb_delay_module_2.sv
// Scoreboard bench for delay_module_2 with T10MS=9, TLONG=29.
module tb_delay_module_2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic h2l;
    logic l2h;
    logic pin_out;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    string nm[3] = '{"press", "release", "long"};

    delay_module_2 #(
        .T10MS (19'd9),
        .TLONG (26'd29)
    ) dut (
        .CLK           (clk),
        .RST_n         (rst_n),
        .H2L_Sig       (h2l),
        .L2H_Sig       (l2h),
        .Pin_Out       (pin_out),
        .Press_Pulse   (press_pulse),
        .Release_Pulse (release_pulse),
        .Long_Pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input int k);
        exp_t e;
        logic exp_pin;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d, required no pulse", nm[k], cyc);
        end else begin
            e       = exp_q.pop_front();
            exp_pin = (k != K_REL);
            if ((e.kind != k) || (e.cyc != cyc) || (pin_out !== exp_pin)) begin
                errors++;
                $display("FAIL event_%s: got %s@%0d pin=%0b, required %s@%0d pin=%0b",
                         nm[e.kind], nm[k], cyc, pin_out, nm[e.kind], e.cyc, exp_pin);
            end
        end
    endtask

    // Monitor: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (press_pulse)   check_evt(K_PRESS);
            if (release_pulse) check_evt(K_REL);
            if (long_pulse)    check_evt(K_LONG);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic l);
        h2l = h;
        l2h = l;
        @(posedge clk);
        #1;
        h2l = 1'b0;
        l2h = 1'b0;
    endtask

    int t0;
    int t1;

    initial begin
        rst_n = 1'b0;
        h2l   = 1'b0;
        l2h   = 1'b0;
        idle(3);
        chk("rst_pin", pin_out, 1'b0);
        chk("rst_press", press_pulse, 1'b0);
        chk("rst_release", release_pulse, 1'b0);
        chk("rst_long", long_pulse, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Clean press
        t0 = cyc;
        push(K_PRESS, t0 + 11);
        drive(1'b1, 1'b0);
        idle(15);
        chk("clean_press_pin", pin_out, 1'b1);

        // Clean release
        t0 = cyc;
        push(K_REL, t0 + 11);
        drive(1'b0, 1'b1);
        idle(15);
        chk("clean_release_pin", pin_out, 1'b0);

        // Press bounce at cycle 4
        drive(1'b1, 1'b0);
        idle(3);
        drive(1'b0, 1'b1);
        idle(15);
        chk("press_bounce_pin", pin_out, 1'b0);

        // Bounce on last window cycle still cancels
        drive(1'b1, 1'b0);
        idle(9);
        drive(1'b0, 1'b1);
        idle(15);
        chk("late_bounce_pin", pin_out, 1'b0);

        // Repeated H2L restarts latency
        drive(1'b1, 1'b0);
        idle(4);
        t1 = cyc;
        push(K_PRESS, t1 + 11);
        drive(1'b1, 1'b0);
        idle(15);
        chk("restart_pin", pin_out, 1'b1);

        // Release bounce at cycle 5
        drive(1'b0, 1'b1);
        idle(4);
        drive(1'b1, 1'b0);
        idle(15);
        chk("release_bounce_pin", pin_out, 1'b1);

        // Release then back-to-back press right after the release pulse
        t0 = cyc;
        push(K_REL, t0 + 11);
        drive(1'b0, 1'b1);
        idle(10);
        chk("b2b_release_pin", pin_out, 1'b0);
        idle(1);
        t1 = cyc;
        push(K_PRESS, t1 + 11);
`ifdef DELAY_LONG_PRESS_EN
        push(K_LONG, t1 + 41);
`endif
        drive(1'b1, 1'b0);
        idle(110);
        chk("long_hold_pin", pin_out, 1'b1);

        t0 = cyc;
        push(K_REL, t0 + 11);
        drive(1'b0, 1'b1);
        idle(15);
        chk("long_release_pin", pin_out, 1'b0);

        // Simultaneous edges in IDLE
        drive(1'b1, 1'b1);
        idle(15);
        chk("simul_idle_pin", pin_out, 1'b0);

        // Reset at cycle 6 of PRESS_FILT
        drive(1'b1, 1'b0);
        idle(5);
        rst_n = 1'b0;
        #1;
        chk("rst_filt_pin", pin_out, 1'b0);
        chk("rst_filt_press", press_pulse, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(20);
        chk("rst_filt_after_pin", pin_out, 1'b0);

        // Asynchronous reset while held
        t0 = cyc;
        push(K_PRESS, t0 + 11);
        drive(1'b1, 1'b0);
        idle(12);
        chk("pre_rst_held_pin", pin_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pin", pin_out, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(5);
        drive(1'b0, 1'b1);
        idle(40);
        chk("post_rst_pin", pin_out, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
